// File: rtl/dz_rx_scan.sv
// DZ11 receive scanner: round-robin over eight UART receivers, grants the
// single RBUF silo write port to one full receiver at a time.
module dz_rx_scan #(
   parameter int SCANDIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        csrMSE,
   input  logic [7:0]  uartRXFULL,
   input  logic [63:0] uartRXDATA,
   input  logic [7:0]  uartRXPERR,
   input  logic [7:0]  uartRXFERR,
   input  logic [7:0]  uartRXOVRE,
   input  logic        siloFULL,
   output logic [7:0]  uartRXCLR,
   output logic        siloWR,
   output logic [15:0] siloDATA,
   output logic [2:0]  rxSCAN
);

   typedef enum logic [1:0] {ST_SCAN, ST_LOAD, ST_WAIT} state_t;

   localparam logic [7:0] DIV_LAST = 8'(SCANDIV - 1);

   state_t      state;
   logic [2:0]  scan;
   logic [2:0]  line;
   logic [7:0]  divcnt;
   logic [7:0]  cur_char;

   assign cur_char = uartRXDATA[8*scan +: 8];
   assign rxSCAN   = scan;

   // The RBUF word and strobes are registered on the examining edge so they
   // are presented during the single LOAD cycle.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state     <= ST_SCAN;
         scan      <= 3'd0;
         line      <= 3'd0;
         divcnt    <= 8'd0;
         uartRXCLR <= 8'd0;
         siloWR    <= 1'b0;
         siloDATA  <= 16'd0;
      end else begin
         uartRXCLR <= 8'd0;
         siloWR    <= 1'b0;
         siloDATA  <= 16'd0;
         case (state)
            ST_SCAN: begin
               if (csrMSE) begin
                  if (divcnt != DIV_LAST) begin
                     divcnt <= divcnt + 8'd1;
                  end else begin
                     divcnt <= 8'd0;
                     if (uartRXFULL[scan]) begin
                        // A full silo stalls on this line instead of skipping it.
                        if (!siloFULL) begin
                           line      <= scan;
                           state     <= ST_LOAD;
                           siloWR    <= 1'b1;
                           uartRXCLR <= 8'd1 << scan;
                           siloDATA  <= {1'b1, uartRXOVRE[scan], uartRXFERR[scan],
                                         uartRXPERR[scan], 1'b0, scan, cur_char};
                        end
                     end else begin
                        scan <= scan + 3'd1;
                     end
                  end
               end
            end
            ST_LOAD: state <= ST_WAIT;
            ST_WAIT: begin
               // Resume past the granted line so it is never re-granted back-to-back.
               if (!uartRXFULL[line]) begin
                  scan   <= line + 3'd1;
                  divcnt <= 8'd0;
                  state  <= ST_SCAN;
               end
            end
            default: state <= ST_SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_dz_rx_scan.sv
// Bench for dz_rx_scan: a UART/silo responder, an RBUF scoreboard fed from a
// line-order model, and directed plus randomized scenarios.
module tb_dz_rx_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clr, mse, silo_full;
   logic [7:0]  full, perr, ferr, ovre;
   logic [63:0] data;
   logic [7:0]  rx_clr;
   logic        silo_wr;
   logic [15:0] silo_data;
   logic [2:0]  rx_scan;

   logic        mse4;
   logic [7:0]  rx_clr4;
   logic        silo_wr4;
   logic [15:0] silo_data4;
   logic [2:0]  rx_scan4;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          last_wr = -100;
   bit          hold_clr = 1'b0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_word[8];
   logic [15:0] mon_e;

   dz_rx_scan #(.SCANDIV(1)) dut (
      .clk(clk), .rst(rst), .clr(clr), .csrMSE(mse),
      .uartRXFULL(full), .uartRXDATA(data), .uartRXPERR(perr),
      .uartRXFERR(ferr), .uartRXOVRE(ovre), .siloFULL(silo_full),
      .uartRXCLR(rx_clr), .siloWR(silo_wr), .siloDATA(silo_data),
      .rxSCAN(rx_scan)
   );

   dz_rx_scan #(.SCANDIV(4)) dut4 (
      .clk(clk), .rst(rst), .clr(1'b0), .csrMSE(mse4),
      .uartRXFULL(8'd0), .uartRXDATA(64'd0), .uartRXPERR(8'd0),
      .uartRXFERR(8'd0), .uartRXOVRE(8'd0), .siloFULL(1'b0),
      .uartRXCLR(rx_clr4), .siloWR(silo_wr4), .siloDATA(silo_data4),
      .rxSCAN(rx_scan4)
   );

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rbuf(input int n, input logic [7:0] ch,
                                        input bit p, input bit f, input bit o);
      return 16'h8000 | (o ? 16'h4000 : 16'h0) | (f ? 16'h2000 : 16'h0) |
             (p ? 16'h1000 : 16'h0) | (16'(n) << 8) | 16'(ch);
   endfunction

   // One clock; the UART model drops FULL on any line the DUT clears.
   task automatic step();
      @(negedge clk);
      if (!hold_clr) full = full & ~rx_clr;
   endtask

   task automatic put(input int n, input logic [7:0] ch, input bit p, input bit f, input bit o);
      data[8*n +: 8] = ch;
      perr[n] = p;
      ferr[n] = f;
      ovre[n] = o;
      full[n] = 1'b1;
      exp_word[n] = rbuf(n, ch, p, f, o);
   endtask

   task automatic put_rand(input int n);
      put(n, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
   endtask

   // Round-robin service order: the first full line at or after ptr, cyclically.
   task automatic push_order(input int ptr, input logic [7:0] mask);
      for (int i = 0; i < 8; i++) begin
         int l = (ptr + i) % 8;
         if (mask[l]) exp_q.push_back(exp_word[l]);
      end
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic wait_wr(input int budget);
      int n = 0;
      while (!silo_wr && n < budget) begin
         step();
         n++;
      end
      check("wait_wr_timeout", 16'(silo_wr), 16'd1);
   endtask

   task automatic wait_drain(input int budget, input bit rnd_full);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         if (rnd_full) silo_full = ($urandom_range(0, 3) == 0);
         step();
         n++;
      end
      silo_full = 1'b0;
      check("drain_left", 16'(exp_q.size()), 16'd0);
      exp_q.delete();
      repeat (4) step();
   endtask

   // Monitor: every silo write must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && !clr) begin
         if (silo_wr) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got %h expected none", silo_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("silo_data", silo_data, mon_e);
               check("rx_clr_onehot", 16'(rx_clr), 16'(8'd1 << mon_e[10:8]));
            end
            check("wr_spacing", 16'(cyc - last_wr > 2), 16'd1);
            last_wr = cyc;
         end else begin
            check("rx_clr_idle", 16'(rx_clr), 16'd0);
         end
      end
   end

   initial begin
      rst = 1'b1; clr = 1'b0; mse = 1'b0; mse4 = 1'b0; silo_full = 1'b0;
      full = 8'd0; perr = 8'd0; ferr = 8'd0; ovre = 8'd0; data = 64'd0;
      for (int i = 0; i < 8; i++) exp_word[i] = 16'd0;
      repeat (3) step();
      rst = 1'b0;
      check("rst_silo_wr", 16'(silo_wr), 16'd0);
      check("rst_silo_data", silo_data, 16'd0);
      check("rst_rx_scan", 16'(rx_scan), 16'd0);
      check("rst_rx_clr", 16'(rx_clr), 16'd0);
      check("rst_rx_scan4", 16'(rx_scan4), 16'd0);

      // Divided scan rate on an idle bank, through the 7->0 wrap.
      mse4 = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         check("scandiv4_ptr", 16'(rx_scan4), 16'((k / 4) % 8));
      end
      mse4 = 1'b0;

      // Line 3 alone: write lands four clocks after scan enable.
      put(3, 8'h41, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(exp_word[3]);
      mse = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         check("t1_no_early_wr", 16'(silo_wr), 16'd0);
      end
      step();
      check("t1_wr_cycle4", 16'(silo_wr), 16'd1);
      check("t1_data", silo_data, 16'h8341);
      check("t1_clr", 16'(rx_clr), 16'h0008);
      wait_drain(50, 1'b0);

      // Lines 1 and 6 together from pointer 0, then pointer resumes at 7.
      mse = 1'b0;
      clr_pulse();
      put_rand(6);
      put_rand(1);
      push_order(0, 8'h42);
      mse = 1'b1;
      begin
         int n = 0;
         step();
         while (!(silo_wr && silo_data[10:8] == 3'd6) && n < 100) begin
            step();
            n++;
         end
         check("t2_line6_seen", 16'(silo_wr), 16'd1);
      end
      step();
      step();
      check("t2_resume_ptr", 16'(rx_scan), 16'd7);
      mse = 1'b0;
      check("t2_queue_empty", 16'(exp_q.size()), 16'd0);

      // All lines full with scan disabled, then drain from the held pointer.
      for (int l = 0; l < 8; l++) put_rand(l);
      repeat (100) step();
      check("t6_ptr_held", 16'(rx_scan), 16'd7);
      push_order(7, 8'hFF);
      mse = 1'b1;
      wait_drain(400, 1'b0);

      // Silo full stalls on line 2; releasing it yields the flagged word.
      mse = 1'b0;
      clr_pulse();
      put(2, 8'($urandom), 1'b1, 1'b0, 1'b1);
      silo_full = 1'b1;
      mse = 1'b1;
      repeat (20) step();
      check("t3_stall_ptr", 16'(rx_scan), 16'd2);
      exp_q.push_back(exp_word[2]);
      silo_full = 1'b0;
      wait_wr(20);
      check("t3_flags_line", 16'(silo_data[15:8]), 16'h00D2);
      wait_drain(50, 1'b0);

      // Device clear while waiting on a receiver that has not dropped FULL.
      mse = 1'b0;
      clr_pulse();
      hold_clr = 1'b1;
      put_rand(5);
      exp_q.push_back(exp_word[5]);
      mse = 1'b1;
      wait_wr(50);
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t4_clr_ptr", 16'(rx_scan), 16'd0);
      check("t4_clr_wr", 16'(silo_wr), 16'd0);
      check("t4_clr_rxclr", 16'(rx_clr), 16'd0);
      hold_clr = 1'b0;
      exp_q.push_back(exp_word[5]);
      wait_drain(100, 1'b0);

      // Random line sets and characters with a randomly busy silo.
      for (int b = 0; b < 12; b++) begin
         logic [7:0] mask;
         mse = 1'b0;
         silo_full = 1'b0;
         clr_pulse();
         mask = 8'($urandom_range(1, 255));
         for (int l = 0; l < 8; l++) if (mask[l]) put_rand(l);
         push_order(0, mask);
         mse = 1'b1;
         wait_drain(1000, 1'b1);
      end

      mse = 1'b0;
      repeat (5) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
